// File: rtl/serial_alu.sv
// Chunk-serial ALU for the multi-cycle MIPS execute stage: CHUNK bits per clock,
// LSB chunk first, with the ripple carry held in a register between chunks.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } op_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic             ill_q;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [IW-1:0]    idx;
  logic             carry;

  logic [CHUNK-1:0] a_c, b_c, sum_c, res_c;
  logic             cout, cmsb, last, v, slt_bit, ovf_final;
  logic [WIDTH-1:0] full, res_final;
  logic             sub_in, legal_in;

  assign sub_in   = (control == OP_SUB) || (control == OP_SLT);
  assign legal_in = control inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};

  // One chunk of the datapath; on the last chunk the full result is assembled
  // from the accumulator so no partial value ever reaches the outputs.
  always_comb begin
    a_c  = a_q[idx*CHUNK +: CHUNK];
    b_c  = b_q[idx*CHUNK +: CHUNK];
    {cout, sum_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
    cmsb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1];
    last = (idx == IW'(NCHUNK - 1));
    case (op_q)
      OP_OR:                  res_c = a_c | b_c;
      OP_NOR:                 res_c = ~(a_c | b_c);
      OP_ADD, OP_SUB, OP_SLT: res_c = sum_c;
      default:                res_c = a_c & b_c;
    endcase
    full = acc;
    full[idx*CHUNK +: CHUNK] = res_c;

    // Overflow-corrected sign gives a true signed less-than for SLT.
    v         = cmsb ^ cout;
    slt_bit   = sum_c[CHUNK-1] ^ v;
    res_final = full;
    ovf_final = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: ovf_final = v;
      OP_SLT: begin
        res_final    = '0;
        res_final[0] = slt_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      ill_q    <= 1'b0;
      acc      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= sub_in ? ~b : b;
            op_q  <= control;
            ill_q <= !legal_in;
            acc   <= '0;
            idx   <= '0;
            carry <= sub_in;
          end
        end
        RUN: begin
          acc   <= full;
          carry <= cout;
          if (!last) idx <= idx + 1'b1;
          if (last) begin
            result   <= res_final;
            zero     <= (res_final == '0);
            overflow <= ovf_final;
            illegal  <= ill_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
